// File: rtl/countdown_sequencer.sv
// Game countdown controller: a BCD tenths-of-second timer with run, pause,
// resume, expiry and abort, plus the tick prescaler that paces the count.
module countdown_sequencer #(
    parameter int unsigned CLK_DIV      = 5000000,
    parameter int unsigned START_TENTHS = 1800,
    parameter int unsigned WARN_TENTHS  = 100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        abort,
    output logic [15:0] remaining,
    output logic [1:0]  state,
    output logic        running,
    output logic        paused,
    output logic        warning,
    output logic        expire_pulse,
    output logic        game_over
);

    // state   | meaning
    // IDLE    | loaded with the start value, waiting for start
    // RUNNING | prescaler counting, remaining decrements on each tick
    // PAUSED  | prescaler and remaining frozen, start resumes
    // EXPIRED | count reached zero, only abort leaves
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUNNING = 2'b01;
    localparam logic [1:0] ST_PAUSED  = 2'b10;
    localparam logic [1:0] ST_EXPIRED = 2'b11;

    localparam logic [23:0] PRESC_LAST = 24'(CLK_DIV - 1);

    // Binary-to-BCD only ever runs on parameters, so the divisions vanish at elaboration.
    function automatic logic [15:0] to_bcd(input int unsigned value);
        to_bcd = {4'((value / 1000) % 10), 4'((value / 100) % 10),
                  4'((value / 10) % 10),   4'(value % 10)};
    endfunction

    function automatic logic [15:0] bcd_decrement(input logic [15:0] value);
        logic [15:0] result;
        logic        borrow;
        result = value;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (value[4*i +: 4] == 4'd0) begin
                    result[4*i +: 4] = 4'd9;
                end else begin
                    result[4*i +: 4] = value[4*i +: 4] - 4'd1;
                    borrow           = 1'b0;
                end
            end
        end
        return result;
    endfunction

    // Packed BCD orders exactly like the number it encodes, digit by digit from the top.
    function automatic logic bcd_at_or_below(input logic [15:0] value, input logic [15:0] limit);
        logic decided;
        logic result;
        decided = 1'b0;
        result  = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            if (!decided && value[4*i +: 4] != limit[4*i +: 4]) begin
                decided = 1'b1;
                result  = value[4*i +: 4] < limit[4*i +: 4];
            end
        end
        return result;
    endfunction

    localparam logic [15:0] START_BCD = to_bcd(START_TENTHS);
    localparam logic [15:0] WARN_BCD  = to_bcd(WARN_TENTHS);

    logic [23:0] prescaler;
    logic [23:0] prescaler_nxt;
    logic [15:0] remaining_nxt;
    logic [1:0]  state_nxt;
    logic        tick;
    logic        expiring;
    logic        warning_nxt;

    assign tick = (state == ST_RUNNING) && (prescaler == PRESC_LAST);

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        prescaler_nxt = prescaler;
        expiring      = 1'b0;
        if (abort) begin
            state_nxt     = ST_IDLE;
            remaining_nxt = START_BCD;
            prescaler_nxt = 24'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    prescaler_nxt = 24'd0;
                    if (start) begin
                        state_nxt = ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    if (tick) begin
                        prescaler_nxt = 24'd0;
                        if (remaining == 16'h0001) begin
                            remaining_nxt = 16'h0000;
                            state_nxt     = ST_EXPIRED;
                            expiring      = 1'b1;
                        end else begin
                            remaining_nxt = bcd_decrement(remaining);
                            if (pause) begin
                                state_nxt = ST_PAUSED;
                            end
                        end
                    end else begin
                        prescaler_nxt = prescaler + 24'd1;
                        if (pause) begin
                            state_nxt = ST_PAUSED;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (start) begin
                        state_nxt = ST_RUNNING;
                    end
                end
                default: begin
                    prescaler_nxt = 24'd0;
                end
            endcase
        end
    end

    assign warning_nxt = ((state_nxt == ST_RUNNING) || (state_nxt == ST_PAUSED))
                         && bcd_at_or_below(remaining_nxt, WARN_BCD);

    // Status flags are registered from the next-state values so they change on the same edge as state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            remaining    <= START_BCD;
            prescaler    <= 24'd0;
            running      <= 1'b0;
            paused       <= 1'b0;
            warning      <= 1'b0;
            expire_pulse <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state        <= state_nxt;
            remaining    <= remaining_nxt;
            prescaler    <= prescaler_nxt;
            running      <= (state_nxt == ST_RUNNING);
            paused       <= (state_nxt == ST_PAUSED);
            warning      <= warning_nxt;
            expire_pulse <= expiring;
            game_over    <= (state_nxt == ST_EXPIRED);
        end
    end

endmodule

// File: doc/countdown_sequencer.md
# countdown_sequencer

Controller that sequences the game countdown: arms, runs, pauses, resumes and expires a 4-digit BCD tenths-of-second countdown. It owns the tick prescaler and the remaining-time register. It drives the 7-segment display multiplexer and the game-over logic. Time is held in BCD with digit-wise borrow, so no dividers are used anywhere in the datapath.

## Interface
- CLK_DIV, 5000000, clock cycles per countdown unit (0.1 s at 50 MHz); legal range 2..2^24-1
- START_TENTHS, 1800, load value in tenths of a second; legal range 1..9999
- WARN_TENTHS, 100, warning threshold in tenths; legal range 0..9999

- clock  in  1  system clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high; clock is `clock`
- start  in  1  one-cycle pulse, already synchronised; start or resume
- pause  in  1  one-cycle pulse, synchronised; pause a running count
- abort  in  1  one-cycle pulse, synchronised; return to IDLE and reload
- remaining  out  16  BCD digits {thousands, hundreds, tens, units} in tenths of a second
- state  out  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 EXPIRED
- running  out  1  high in RUNNING
- paused  out  1  high in PAUSED
- warning  out  1  high in RUNNING or PAUSED when remaining <= WARN_TENTHS
- expire_pulse  out  1  one-cycle strobe on entry to EXPIRED
- game_over  out  1  level, high in EXPIRED

## Operation
- Reset values:
  - state IDLE
  - remaining = BCD(START_TENTHS)
  - prescaler 0
  - running, paused, warning, expire_pulse and game_over all 0
- Prescaler behaviour:
  - Counts 0..CLK_DIV-1 only while in RUNNING; holds its value in PAUSED.
  - Clears to 0 in IDLE and EXPIRED.
  - tick = RUNNING and prescaler == CLK_DIV-1; the prescaler wraps to 0 on tick.
- On tick, remaining is decremented by 1 in BCD:
  - A units digit of 0 becomes 9 and borrows from tens; borrow ripples through all four digits.
  - Example: 1000 -> 0999.
- State transitions:
  - IDLE: start -> RUNNING. pause is ignored.
  - RUNNING: pause -> PAUSED. A tick with remaining == 0001 sets remaining to 0000 and moves to EXPIRED. start is ignored.
  - PAUSED: start -> RUNNING; the prescaler resumes from its held value. pause is ignored.
  - EXPIRED: start and pause are ignored; abort is the only exit.
  - Any state: abort -> IDLE, remaining reloads to BCD(START_TENTHS), prescaler clears.
- Priority within one cycle is abort > tick > pause > start.
  - tick and pause together: the decrement is applied and the next state is PAUSED.
  - tick and abort together: the reload wins and no decrement occurs.
  - pause and start together in RUNNING: the next state is PAUSED.
  - tick that expires and pause together: the next state is EXPIRED.
- warning compares BCD digits most-significant first, which is equivalent to a numeric comparison. WARN_TENTHS is converted to BCD at elaboration.
- Reset mid-operation has the same effect as a power-on reset, immediately and asynchronously.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- A start sampled at edge N gives state = RUNNING and running = 1 after edge N. The same applies to pause, abort and resume.
- The first decrement is visible CLK_DIV cycles after entering RUNNING from IDLE.
- After resume, the next decrement is visible (CLK_DIV - held prescaler) cycles later.
- Expiry:
  - remaining = 0000, state = EXPIRED, game_over = 1 and expire_pulse = 1 all appear after the same edge.
  - expire_pulse drops after the following edge.
- warning updates on the same edge as the remaining value or the state that causes it.

## Test plan
- Initial count and borrow (CLK_DIV=4, START_TENTHS=12): reset, then a start pulse.
  - running = 1 on the next cycle.
  - remaining goes 0012 -> 0011 after 4 cycles, then 0010 -> 0009 with the tens borrow.
- Run to expiry (same parameters): after 48 RUNNING cycles, remaining = 0000, state = 11, game_over = 1, and expire_pulse is high for exactly 1 cycle. Later start and pause pulses cause no change. abort -> state 00, remaining 0012, game_over 0.
- Pause and resume: pause when the prescaler is at 2, hold 10 cycles and check remaining is unchanged with paused = 1. Resume with start; the next decrement occurs exactly 2 cycles later.
- Warning threshold (WARN_TENTHS=5): warning goes from 0 to 1 on the edge where remaining becomes 0005. It stays high in PAUSED and clears on abort.
- Simultaneous events:
  - tick + pause -> decremented value, state PAUSED.
  - tick + abort -> remaining 0012, state IDLE.
  - Asynchronous reset mid-count -> outputs at reset values with no clock edge.
- Four-digit borrow (START_TENTHS=1000, CLK_DIV=2): remaining goes 1000 -> 0999 after 2 cycles in RUNNING, and warning stays 0 with WARN_TENTHS=100.
